// File: rtl/paicore_axil_master_if.sv
`default_nettype none
// ============================================================================
// Module   : paicore_axil_master_if
// Purpose  : Command/response, AXI-Lite master and status bundle for
//            paicore_axil_master.
// Revision : 1.0 - initial release
// ============================================================================
interface paicore_axil_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) ();
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic [ADDR_WIDTH-1:0] m_axil_awaddr;
    logic [2:0]            m_axil_awprot;
    logic                  m_axil_awvalid;
    logic                  m_axil_awready;
    logic [DATA_WIDTH-1:0] m_axil_wdata;
    logic [STRB_WIDTH-1:0] m_axil_wstrb;
    logic                  m_axil_wvalid;
    logic                  m_axil_wready;
    logic [1:0]            m_axil_bresp;
    logic                  m_axil_bvalid;
    logic                  m_axil_bready;
    logic [ADDR_WIDTH-1:0] m_axil_araddr;
    logic [2:0]            m_axil_arprot;
    logic                  m_axil_arvalid;
    logic                  m_axil_arready;
    logic [DATA_WIDTH-1:0] m_axil_rdata;
    logic [1:0]            m_axil_rresp;
    logic                  m_axil_rvalid;
    logic                  m_axil_rready;

    logic                  busy;
    logic [31:0]           wr_cnt;
    logic [31:0]           rd_cnt;
    logic [31:0]           err_cnt;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  m_axil_awready, m_axil_wready, m_axil_bresp, m_axil_bvalid,
        input  m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output m_axil_awaddr, m_axil_awprot, m_axil_awvalid,
        output m_axil_wdata, m_axil_wstrb, m_axil_wvalid, m_axil_bready,
        output m_axil_araddr, m_axil_arprot, m_axil_arvalid, m_axil_rready,
        output busy, wr_cnt, rd_cnt, err_cnt
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output m_axil_awready, m_axil_wready, m_axil_bresp, m_axil_bvalid,
        output m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  m_axil_awaddr, m_axil_awprot, m_axil_awvalid,
        input  m_axil_wdata, m_axil_wstrb, m_axil_wvalid, m_axil_bready,
        input  m_axil_araddr, m_axil_arprot, m_axil_arvalid, m_axil_rready,
        input  busy, wr_cnt, rd_cnt, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/paicore_axil_master.sv
`default_nettype none
// ============================================================================
// Module   : paicore_axil_master
// Purpose  : Single-outstanding AXI-Lite master turning simple read/write
//            commands into AXI-Lite transactions, with status counters.
// Revision : 1.0 - initial release
// ============================================================================
module paicore_axil_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    paicore_axil_master_if.master bus
);
    localparam logic [2:0] c_idle    = 3'd0;
    localparam logic [2:0] c_wr_req  = 3'd1;
    localparam logic [2:0] c_wr_resp = 3'd2;
    localparam logic [2:0] c_rd_req  = 3'd3;
    localparam logic [2:0] c_rd_data = 3'd4;
    localparam logic [2:0] c_done    = 3'd5;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_write;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_arvalid;
    logic                  r_err;
    logic [31:0]           r_wr_cnt;
    logic [31:0]           r_rd_cnt;
    logic [31:0]           r_err_cnt;

    logic w_cmd_ready;
    logic w_cmd_fire;
    logic w_aw_ok;
    logic w_w_ok;

    assign w_cmd_ready = (r_state == c_idle) && !rst;
    assign w_cmd_fire  = bus.cmd_valid && w_cmd_ready;
    // A channel is finished once its valid has dropped or handshakes this cycle.
    assign w_aw_ok     = !r_awvalid || bus.m_axil_awready;
    assign w_w_ok      = !r_wvalid  || bus.m_axil_wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_idle;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_write   <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_err     <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_err_cnt <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_cmd_fire) begin
                        r_addr  <= bus.cmd_addr;
                        r_wdata <= bus.cmd_wdata;
                        r_write <= bus.cmd_write;
                        if (bus.cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= c_wr_req;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= c_rd_req;
                        end
                    end
                end
                c_wr_req: begin
                    if (bus.m_axil_awready) r_awvalid <= 1'b0;
                    if (bus.m_axil_wready)  r_wvalid  <= 1'b0;
                    if (w_aw_ok && w_w_ok)  r_state   <= c_wr_resp;
                end
                c_wr_resp: begin
                    if (bus.m_axil_bvalid) begin
                        r_err   <= |bus.m_axil_bresp;
                        r_rdata <= '0;
                        r_state <= c_done;
                    end
                end
                c_rd_req: begin
                    if (bus.m_axil_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= c_rd_data;
                    end
                end
                c_rd_data: begin
                    if (bus.m_axil_rvalid) begin
                        r_rdata <= bus.m_axil_rdata;
                        r_err   <= |bus.m_axil_rresp;
                        r_state <= c_done;
                    end
                end
                c_done: begin
                    if (bus.rsp_ready) begin
                        r_state <= c_idle;
                        if (r_write) r_wr_cnt <= r_wr_cnt + 32'd1;
                        else         r_rd_cnt <= r_rd_cnt + 32'd1;
                        if (r_err && (r_err_cnt != 32'hFFFF_FFFF))
                            r_err_cnt <= r_err_cnt + 32'd1;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign bus.cmd_ready      = w_cmd_ready;
    assign bus.busy           = (r_state != c_idle);
    assign bus.m_axil_awaddr  = r_addr;
    assign bus.m_axil_awprot  = 3'b000;
    assign bus.m_axil_awvalid = r_awvalid;
    assign bus.m_axil_wdata   = r_wdata;
    assign bus.m_axil_wstrb   = {STRB_WIDTH{1'b1}};
    assign bus.m_axil_wvalid  = r_wvalid;
    assign bus.m_axil_bready  = (r_state == c_wr_resp);
    assign bus.m_axil_araddr  = r_addr;
    assign bus.m_axil_arprot  = 3'b000;
    assign bus.m_axil_arvalid = r_arvalid;
    assign bus.m_axil_rready  = (r_state == c_rd_data);
    assign bus.rsp_valid      = (r_state == c_done);
    assign bus.rsp_rdata      = r_rdata;
    assign bus.rsp_err        = r_err;
    assign bus.wr_cnt         = r_wr_cnt;
    assign bus.rd_cnt         = r_rd_cnt;
    assign bus.err_cnt        = r_err_cnt;
endmodule
`default_nettype wire

// File: tb/tb_paicore_axil_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_paicore_axil_master
// Purpose  : Directed self-checking bench with a register-file AXI-Lite slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_paicore_axil_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    paicore_axil_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4)) bus ();

    paicore_axil_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- slave model: register file with per-channel delays
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] mem [0:63];
    int          aw_c, w_c, ar_c, b_c, r_c;
    logic        aw_have, w_have, b_pend, r_pend;
    logic [31:0] s_awaddr, s_wdata, s_araddr;

    assign bus.m_axil_awready = bus.m_axil_awvalid && (aw_c >= aw_dly);
    assign bus.m_axil_wready  = bus.m_axil_wvalid  && (w_c  >= w_dly);
    assign bus.m_axil_arready = bus.m_axil_arvalid && (ar_c >= ar_dly);
    assign bus.m_axil_bvalid  = b_pend && (b_c >= b_dly);
    assign bus.m_axil_bresp   = bresp_cfg;
    assign bus.m_axil_rvalid  = r_pend && (r_c >= r_dly);
    assign bus.m_axil_rresp   = rresp_cfg;
    assign bus.m_axil_rdata   = mem[s_araddr[7:2]];

    always @(posedge clk) begin
        if (rst) begin
            aw_c <= 0; w_c <= 0; ar_c <= 0; b_c <= 0; r_c <= 0;
            aw_have <= 1'b0; w_have <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            s_awaddr <= '0; s_wdata <= '0; s_araddr <= '0;
        end else begin
            aw_c <= (bus.m_axil_awvalid && !bus.m_axil_awready) ? aw_c + 1 : 0;
            w_c  <= (bus.m_axil_wvalid  && !bus.m_axil_wready)  ? w_c + 1  : 0;
            ar_c <= (bus.m_axil_arvalid && !bus.m_axil_arready) ? ar_c + 1 : 0;
            if (bus.m_axil_awvalid && bus.m_axil_awready) begin
                s_awaddr <= bus.m_axil_awaddr; aw_have <= 1'b1;
            end
            if (bus.m_axil_wvalid && bus.m_axil_wready) begin
                s_wdata <= bus.m_axil_wdata; w_have <= 1'b1;
            end
            if (b_pend) begin
                if (bus.m_axil_bvalid && bus.m_axil_bready) begin
                    mem[s_awaddr[7:2]] <= s_wdata;
                    b_pend <= 1'b0; aw_have <= 1'b0; w_have <= 1'b0; b_c <= 0;
                end else b_c <= b_c + 1;
            end else if (aw_have && w_have) b_pend <= 1'b1;
            if (bus.m_axil_arvalid && bus.m_axil_arready) begin
                s_araddr <= bus.m_axil_araddr; r_pend <= 1'b1; r_c <= 0;
            end else if (r_pend) begin
                if (bus.m_axil_rvalid && bus.m_axil_rready) r_pend <= 1'b0;
                else r_c <= r_c + 1;
            end
        end
    end

    // ---------------- protocol monitor
    int          cyc = 0, acc_cyc = 0, first_v_cyc = 0, rsp_cyc = 0;
    logic        seen_v, rsp_seen, both_first;
    int          aw_hs, w_hs, b_hs, b_phases, viol;
    logic        aw_pend, w_pend, ar_pend, aw_fin, w_fin, prev_bready;
    logic [31:0] prev_awaddr, prev_wdata, prev_araddr, mon_awaddr, mon_araddr;
    logic [3:0]  mon_wstrb;
    logic [2:0]  mon_awprot, mon_arprot;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            seen_v = 1'b0; rsp_seen = 1'b0; aw_pend = 1'b0; w_pend = 1'b0; ar_pend = 1'b0;
            aw_fin = 1'b0; w_fin = 1'b0; prev_bready = 1'b0;
        end else begin
            if (aw_pend && !(bus.m_axil_awvalid && bus.m_axil_awaddr == prev_awaddr)) viol++;
            if (w_pend  && !(bus.m_axil_wvalid  && bus.m_axil_wdata  == prev_wdata))  viol++;
            if (ar_pend && !(bus.m_axil_arvalid && bus.m_axil_araddr == prev_araddr)) viol++;
            if (aw_fin && bus.m_axil_awvalid) viol++;
            if (w_fin  && bus.m_axil_wvalid)  viol++;
            aw_pend = bus.m_axil_awvalid && !bus.m_axil_awready;
            w_pend  = bus.m_axil_wvalid  && !bus.m_axil_wready;
            ar_pend = bus.m_axil_arvalid && !bus.m_axil_arready;
            prev_awaddr = bus.m_axil_awaddr; prev_wdata = bus.m_axil_wdata;
            prev_araddr = bus.m_axil_araddr;
            if (bus.m_axil_awvalid && bus.m_axil_awready) begin
                aw_hs++; aw_fin = 1'b1; mon_awaddr = bus.m_axil_awaddr; mon_awprot = bus.m_axil_awprot;
            end
            if (bus.m_axil_wvalid && bus.m_axil_wready) begin
                w_hs++; w_fin = 1'b1; mon_wstrb = bus.m_axil_wstrb;
            end
            if (bus.m_axil_arvalid && bus.m_axil_arready) begin
                mon_araddr = bus.m_axil_araddr; mon_arprot = bus.m_axil_arprot;
            end
            if (bus.m_axil_bvalid && bus.m_axil_bready) b_hs++;
            if (bus.m_axil_bready && !prev_bready) b_phases++;
            prev_bready = bus.m_axil_bready;
            if (!seen_v && (bus.m_axil_awvalid || bus.m_axil_arvalid)) begin
                seen_v = 1'b1; first_v_cyc = cyc;
                both_first = bus.m_axil_awvalid && bus.m_axil_wvalid;
            end
            if (!rsp_seen && bus.rsp_valid) begin rsp_seen = 1'b1; rsp_cyc = cyc; end
            if (bus.cmd_valid && bus.cmd_ready) begin
                acc_cyc = cyc; seen_v = 1'b0; rsp_seen = 1'b0; aw_fin = 1'b0; w_fin = 1'b0;
                aw_hs = 0; w_hs = 0; b_hs = 0; b_phases = 0; viol = 0;
            end
        end
    end

    // ---------------- driver with counter model
    logic [31:0] m_wr = 0, m_rd = 0, m_err = 0;

    task automatic run_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input int hold, input logic [31:0] exp_rd, input logic exp_err);
        int t;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_wdata = d;
        t = 0;
        while (!bus.cmd_ready && t < 100) begin @(negedge clk); t++; end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        t = 0;
        while (!bus.rsp_valid && t < 200) begin @(negedge clk); t++; end
        check_val("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check_val("rsp_rdata", bus.rsp_rdata, exp_rd);
        check_val("rsp_err", {31'd0, bus.rsp_err}, {31'd0, exp_err});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check_val("hold_rdata", bus.rsp_rdata, exp_rd);
            check_val("hold_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
            check_val("hold_cnt", wr ? bus.wr_cnt : bus.rd_cnt, wr ? m_wr : m_rd);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        if (wr) m_wr = m_wr + 1; else m_rd = m_rd + 1;
        if (exp_err && m_err != 32'hFFFF_FFFF) m_err = m_err + 1;
        check_val("wr_cnt", bus.wr_cnt, m_wr);
        check_val("rd_cnt", bus.rd_cnt, m_rd);
        check_val("err_cnt", bus.err_cnt, m_err);
        check_val("idle_after", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int t;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0; bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        check_val("rst_valids", {29'd0, bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_arvalid}, 32'd0);
        check_val("rst_readies", {30'd0, bus.m_axil_bready, bus.m_axil_rready}, 32'd0);
        check_val("rst_rsp", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
        check_val("rst_rdata", bus.rsp_rdata, 32'd0);
        check_val("rst_cnts", bus.wr_cnt | bus.rd_cnt | bus.err_cnt, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

        // Basic write then read-back
        run_cmd(1'b1, 32'h54, 32'h1234_5678, 0, 32'd0, 1'b0);
        check_val("aw_w_same_cycle", {31'd0, both_first}, 32'd1);
        check_val("awaddr", mon_awaddr, 32'h54);
        check_val("awprot", {29'd0, mon_awprot}, 32'd0);
        check_val("wstrb", {28'd0, mon_wstrb}, 32'hF);
        check_val("wr_valid_lat", first_v_cyc - acc_cyc, 32'd1);
        check_val("wr_rsp_min_lat", {31'd0, (rsp_cyc - acc_cyc) >= 3}, 32'd1);
        run_cmd(1'b0, 32'h54, 32'd0, 0, 32'h1234_5678, 1'b0);
        check_val("araddr", mon_araddr, 32'h54);
        check_val("arprot", {29'd0, mon_arprot}, 32'd0);
        check_val("rd_valid_lat", first_v_cyc - acc_cyc, 32'd1);
        check_val("rd_rsp_min_lat", {31'd0, (rsp_cyc - acc_cyc) >= 3}, 32'd1);

        // wready three cycles before awready
        aw_dly = 3; w_dly = 0;
        run_cmd(1'b1, 32'h10, 32'hA5A5_0001, 0, 32'd0, 1'b0);
        check_val("skew_aw_hs", aw_hs, 32'd1);
        check_val("skew_w_hs", w_hs, 32'd1);
        check_val("skew_b_hs", b_hs, 32'd1);
        check_val("skew_b_phases", b_phases, 32'd1);
        check_val("skew_protocol", viol, 32'd0);
        aw_dly = 0; w_dly = 2; b_dly = 3;
        run_cmd(1'b1, 32'h14, 32'h0000_BEEF, 0, 32'd0, 1'b0);
        check_val("skew2_protocol", viol, 32'd0);
        w_dly = 0; b_dly = 0; ar_dly = 2; r_dly = 2;
        run_cmd(1'b0, 32'h10, 32'd0, 0, 32'hA5A5_0001, 1'b0);
        check_val("slow_rd_protocol", viol, 32'd0);
        run_cmd(1'b0, 32'h14, 32'd0, 0, 32'h0000_BEEF, 1'b0);
        ar_dly = 0; r_dly = 0;

        // Error responses and saturation
        rresp_cfg = 2'b10;
        run_cmd(1'b0, 32'h54, 32'd0, 0, 32'h1234_5678, 1'b1);
        rresp_cfg = 2'b00; bresp_cfg = 2'b11;
        run_cmd(1'b1, 32'h30, 32'h0, 0, 32'd0, 1'b1);
        bresp_cfg = 2'b00;
        @(negedge clk);
        force dut.r_err_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_err_cnt;
        m_err = 32'hFFFF_FFFE;
        @(negedge clk);
        check_val("err_preset", bus.err_cnt, 32'hFFFF_FFFE);
        rresp_cfg = 2'b10;
        run_cmd(1'b0, 32'h54, 32'd0, 0, 32'h1234_5678, 1'b1);
        run_cmd(1'b0, 32'h54, 32'd0, 0, 32'h1234_5678, 1'b1);
        check_val("err_saturated", bus.err_cnt, 32'hFFFF_FFFF);
        rresp_cfg = 2'b00;

        // Response backpressure
        run_cmd(1'b0, 32'h10, 32'd0, 10, 32'hA5A5_0001, 1'b0);

        // Reset during WR_RESP
        b_dly = 20;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'h20; bus.cmd_wdata = 32'h1111_2222;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        t = 0;
        while (!bus.m_axil_bready && t < 50) begin @(negedge clk); t++; end
        check_val("reach_wr_resp", {31'd0, bus.m_axil_bready}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_val("abort_valids", {29'd0, bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_arvalid}, 32'd0);
        check_val("abort_readies", {30'd0, bus.m_axil_bready, bus.m_axil_rready}, 32'd0);
        check_val("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check_val("abort_busy", {31'd0, bus.busy}, 32'd0);
        check_val("abort_cnts", bus.wr_cnt | bus.rd_cnt | bus.err_cnt, 32'd0);
        check_val("abort_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        rst = 1'b0;
        m_wr = 0; m_rd = 0; m_err = 0; b_dly = 0;
        @(negedge clk);
        check_val("abort_cmd_ready_rel", {31'd0, bus.cmd_ready}, 32'd1);
        run_cmd(1'b1, 32'h20, 32'h0BAD_F00D, 0, 32'd0, 1'b0);
        run_cmd(1'b0, 32'h20, 32'd0, 0, 32'h0BAD_F00D, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/paicore_axil_master.md
PAICORE_AXIL_MASTER -- requirements
Module: paicore_axil_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI-Lite data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, AXI-Lite address width.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, write strobe width.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cmd_valid  input  1  command request.
REQ-007 SHALL have port cmd_ready  output  1  command accepted.
REQ-008 SHALL have port cmd_write  input  1  1=write, 0=read.
REQ-009 SHALL have port cmd_addr  input  ADDR_WIDTH  byte address.
REQ-010 SHALL have port cmd_wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have ports rsp_valid output 1, rsp_ready input 1: completion handshake.
REQ-012 SHALL have ports rsp_rdata output DATA_WIDTH (read data), rsp_err output 1 (resp != OKAY).
REQ-013 SHALL have AW ports m_axil_awaddr out ADDR_WIDTH, awprot out 3, awvalid out 1, awready in 1.
REQ-014 SHALL have W ports m_axil_wdata out DATA_WIDTH, wstrb out STRB_WIDTH, wvalid out 1, wready in 1.
REQ-015 SHALL have B ports m_axil_bresp in 2, bvalid in 1, bready out 1.
REQ-016 SHALL have AR ports m_axil_araddr out ADDR_WIDTH, arprot out 3, arvalid out 1, arready in 1.
REQ-017 SHALL have R ports m_axil_rdata in DATA_WIDTH, rresp in 2, rvalid in 1, rready out 1.
REQ-018 SHALL have outputs busy 1, wr_cnt 32, rd_cnt 32, err_cnt 32 (status).

Function
REQ-019 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
REQ-020 SHALL drive cmd_ready=1 only in IDLE; busy = (state != IDLE).
REQ-021 On cmd_valid&cmd_ready SHALL latch cmd_addr/cmd_wdata/cmd_write; next state WR_REQ if write else RD_REQ.
REQ-022 In WR_REQ SHALL assert awvalid and wvalid together on the first cycle (slave requires both simultaneously).
REQ-023 awvalid SHALL deassert the cycle after awvalid&awready; wvalid likewise with wready; each independent.
REQ-024 Address/data/strobe SHALL stay stable while the corresponding valid is high; wstrb all-ones; awprot=arprot=3'b000.
REQ-025 After both AW and W handshakes complete SHALL enter WR_RESP with bready=1; bready=0 in all other states.
REQ-026 On bvalid&bready SHALL capture bresp, set rsp_rdata=0, enter DONE.
REQ-027 In RD_REQ SHALL assert arvalid until arvalid&arready, then enter RD_DATA.
REQ-028 In RD_DATA SHALL assert rready=1; on rvalid&rready capture rdata and rresp, enter DONE; rready=0 elsewhere.
REQ-029 In DONE SHALL hold rsp_valid=1 with stable rsp_rdata/rsp_err until rsp_ready, then return to IDLE.
REQ-030 rsp_err SHALL be 1 when captured resp != 2'b00.
REQ-031 Minimum latency: command accept cycle N, valids high N+1, rsp_valid no earlier than N+3 for writes and reads.
REQ-032 Backpressure of any duration on any AXI channel or rsp_ready SHALL only stall; no timeout, no valid withdrawn.
REQ-033 On each DONE->IDLE exit SHALL increment wr_cnt or rd_cnt (mod 2^32 wrap) and, if rsp_err, err_cnt (saturating at 0xFFFFFFFF).
REQ-034 SHALL have at most one transaction outstanding; no new command accepted until DONE completes.

Reset
REQ-035 rst SHALL force state IDLE, all AXI valid/ready outputs 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, counters 0, cmd_ready 0 during rst, 1 the cycle after release.
REQ-036 rst mid-transaction SHALL abort immediately with outputs as REQ-035; pending slave handshakes are discarded.

Verification
REQ-037 Write 0x1234_5678 to 0x54 with register-file slave -> awvalid/wvalid high same cycle, awaddr 0x54, rsp_valid rsp_err=0, wr_cnt=1.
REQ-038 Read 0x54 after REQ-037 -> araddr 0x54, rsp_rdata 0x1234_5678, rd_cnt=1.
REQ-039 Slave gives wready 3 cycles before awready -> wvalid drops after its handshake, awvalid held, single bready phase, one response.
REQ-040 Slave returns rresp=2'b10 -> rsp_err=1, err_cnt=1; err_cnt preset near max saturates at 0xFFFFFFFF.
REQ-041 rsp_ready held low 10 cycles -> rsp_valid/rsp_rdata stable, cmd_ready 0 throughout; counters update only on release.
REQ-042 rst asserted while in WR_RESP -> next cycle all valids/bready 0, state IDLE, counters 0, next command completes normally.
